ux607_icb2tl_bridge: RTL and testbench

//  Parametrised ICB-slave to TileLink-UL-master bridge for ux607 peripherals (QSPI, future TL-UL perips).

---
 rtl/ux607_icb2tl_bridge.sv | 147 ++++++++++++++
 tb/tb_ux607_icb2tl_bridge.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ux607_icb2tl_bridge.sv
// ICB-slave to TileLink-UL-master bridge: combinational A path with credit limit,
// rolling source IDs, and an OUTS-deep registered response FIFO on the D side.
module ux607_icb2tl_bridge #(
    parameter int AW    = 32,
    parameter int TL_AW = 29,
    parameter int DW    = 32,
    parameter int OUTS  = 2,
    parameter int SRC_W = 5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                i_icb_cmd_valid,
    output logic                i_icb_cmd_ready,
    input  logic [AW-1:0]       i_icb_cmd_addr,
    input  logic                i_icb_cmd_read,
    input  logic [DW-1:0]       i_icb_cmd_wdata,
    input  logic [DW/8-1:0]     i_icb_cmd_wmask,
    output logic                i_icb_rsp_valid,
    input  logic                i_icb_rsp_ready,
    output logic [DW-1:0]       i_icb_rsp_rdata,
    output logic                i_icb_rsp_err,
    output logic                tl_a_valid,
    input  logic                tl_a_ready,
    output logic [2:0]          tl_a_opcode,
    output logic [2:0]          tl_a_param,
    output logic [2:0]          tl_a_size,
    output logic [SRC_W-1:0]    tl_a_source,
    output logic [TL_AW-1:0]    tl_a_address,
    output logic [DW/8-1:0]     tl_a_mask,
    output logic [DW-1:0]       tl_a_data,
    input  logic                tl_d_valid,
    output logic                tl_d_ready,
    input  logic [2:0]          tl_d_opcode,
    input  logic [SRC_W-1:0]    tl_d_source,
    input  logic [DW-1:0]       tl_d_data,
    input  logic                tl_d_error,
    output logic                busy,
    output logic                order_err
);
    localparam int OFF_W = $clog2(DW / 8);
    localparam int PTR_W = (OUTS > 1) ? $clog2(OUTS) : 1;
    localparam int CNT_W = $clog2(OUTS + 1);
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(OUTS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OUTS);

    localparam logic [2:0] OP_GET         = 3'd4;
    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_ACK_DATA    = 3'd1;

    typedef struct packed {
        logic          err;
        logic [DW-1:0] data;
    } rsp_entry_t;

    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] fifo_cnt;
    logic [PTR_W-1:0] a_ptr;
    logic [PTR_W-1:0] d_ptr;
    logic [PTR_W-1:0] rd_ptr;
    rsp_entry_t       fifo_mem [OUTS];
    logic             credit;
    logic             fifo_full;
    logic             a_fire;
    logic             d_fire;
    logic             rsp_fire;
    logic             unused_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_MAX) ? '0 : p + PTR_W'(1);
    endfunction

    assign credit          = outstanding < CNT_MAX;
    assign tl_a_valid      = i_icb_cmd_valid & credit;
    assign i_icb_cmd_ready = tl_a_ready & credit;
    assign a_fire          = i_icb_cmd_valid & tl_a_ready & credit;

    assign fifo_full       = fifo_cnt == CNT_MAX;
    assign tl_d_ready      = ~fifo_full;
    assign d_fire          = tl_d_valid & ~fifo_full;
    assign i_icb_rsp_valid = fifo_cnt != '0;
    assign rsp_fire        = i_icb_rsp_valid & i_icb_rsp_ready;
    assign i_icb_rsp_rdata = fifo_mem[rd_ptr].data;
    assign i_icb_rsp_err   = fifo_mem[rd_ptr].err;
    assign busy            = outstanding != '0;

    assign tl_a_param   = 3'd0;
    assign tl_a_size    = 3'(OFF_W);
    assign tl_a_source  = SRC_W'(a_ptr);
    assign tl_a_address = {i_icb_cmd_addr[TL_AW-1:OFF_W], {OFF_W{1'b0}}};
    assign tl_a_data    = i_icb_cmd_wdata;

    // Upper address bits and the sub-word offset are intentionally dropped.
    assign unused_ok = &{1'b0, i_icb_cmd_addr[AW-1:TL_AW], i_icb_cmd_addr[OFF_W-1:0]};

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        tl_a_opcode = OP_PUT_PARTIAL;
        tl_a_mask   = i_icb_cmd_wmask;
        if (i_icb_cmd_read) begin
            tl_a_opcode = OP_GET;
            tl_a_mask   = '1;
        end else if (&i_icb_cmd_wmask) begin
            tl_a_opcode = OP_PUT_FULL;
        end
    end

    // NOTE: registers use non-blocking assignments so each one samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            outstanding <= '0;
            fifo_cnt    <= '0;
            a_ptr       <= '0;
            d_ptr       <= '0;
            rd_ptr      <= '0;
            order_err   <= 1'b0;
        end else begin
            if (a_fire && !rsp_fire)
                outstanding <= outstanding + CNT_W'(1);
            else if (!a_fire && rsp_fire)
                outstanding <= outstanding - CNT_W'(1);

            if (d_fire && !rsp_fire)
                fifo_cnt <= fifo_cnt + CNT_W'(1);
            else if (!d_fire && rsp_fire)
                fifo_cnt <= fifo_cnt - CNT_W'(1);

            if (a_fire)
                a_ptr <= ptr_inc(a_ptr);
            if (rsp_fire)
                rd_ptr <= ptr_inc(rd_ptr);
            if (d_fire) begin
                d_ptr <= ptr_inc(d_ptr);
                if (tl_d_source != SRC_W'(d_ptr))
                    order_err <= 1'b1;
            end
        end
    end

    // NOTE: response storage has no reset; fifo_cnt gates visibility, so stale entries never reach ICB.
    always_ff @(posedge clock) begin
        if (d_fire) begin
            fifo_mem[d_ptr].err  <= tl_d_error;
            fifo_mem[d_ptr].data <= (tl_d_opcode == OP_ACK_DATA) ? tl_d_data : '0;
        end
    end
endmodule

// File: tb/tb_ux607_icb2tl_bridge.sv
// Self-checking bench for ux607_icb2tl_bridge: A-path vector table, directed corner
// sequences, and a randomized run against a queue-based transaction model.
module tb_ux607_icb2tl_bridge;
    localparam int AW = 32, TL_AW = 29, DW = 32, OUTS = 2, SRC_W = 5;

    logic              clock = 1'b0;
    logic              reset;
    logic              i_icb_cmd_valid, i_icb_cmd_ready;
    logic [AW-1:0]     i_icb_cmd_addr;
    logic              i_icb_cmd_read;
    logic [DW-1:0]     i_icb_cmd_wdata;
    logic [DW/8-1:0]   i_icb_cmd_wmask;
    logic              i_icb_rsp_valid, i_icb_rsp_ready;
    logic [DW-1:0]     i_icb_rsp_rdata;
    logic              i_icb_rsp_err;
    logic              tl_a_valid, tl_a_ready;
    logic [2:0]        tl_a_opcode, tl_a_param, tl_a_size;
    logic [SRC_W-1:0]  tl_a_source;
    logic [TL_AW-1:0]  tl_a_address;
    logic [DW/8-1:0]   tl_a_mask;
    logic [DW-1:0]     tl_a_data;
    logic              tl_d_valid, tl_d_ready;
    logic [2:0]        tl_d_opcode;
    logic [SRC_W-1:0]  tl_d_source;
    logic [DW-1:0]     tl_d_data;
    logic              tl_d_error;
    logic              busy, order_err;

    always #5 clock = ~clock;

    ux607_icb2tl_bridge #(.AW(AW), .TL_AW(TL_AW), .DW(DW), .OUTS(OUTS), .SRC_W(SRC_W)) dut (
        .clock(clock), .reset(reset),
        .i_icb_cmd_valid(i_icb_cmd_valid), .i_icb_cmd_ready(i_icb_cmd_ready),
        .i_icb_cmd_addr(i_icb_cmd_addr), .i_icb_cmd_read(i_icb_cmd_read),
        .i_icb_cmd_wdata(i_icb_cmd_wdata), .i_icb_cmd_wmask(i_icb_cmd_wmask),
        .i_icb_rsp_valid(i_icb_rsp_valid), .i_icb_rsp_ready(i_icb_rsp_ready),
        .i_icb_rsp_rdata(i_icb_rsp_rdata), .i_icb_rsp_err(i_icb_rsp_err),
        .tl_a_valid(tl_a_valid), .tl_a_ready(tl_a_ready), .tl_a_opcode(tl_a_opcode),
        .tl_a_param(tl_a_param), .tl_a_size(tl_a_size), .tl_a_source(tl_a_source),
        .tl_a_address(tl_a_address), .tl_a_mask(tl_a_mask), .tl_a_data(tl_a_data),
        .tl_d_valid(tl_d_valid), .tl_d_ready(tl_d_ready), .tl_d_opcode(tl_d_opcode),
        .tl_d_source(tl_d_source), .tl_d_data(tl_d_data), .tl_d_error(tl_d_error),
        .busy(busy), .order_err(order_err)
    );

    typedef struct {
        logic        read;
        logic [31:0] addr;
        logic [3:0]  wmask;
        logic [2:0]  exp_opcode;
        logic [28:0] exp_addr;
        logic [3:0]  exp_mask;
    } vec_t;

    typedef struct {
        logic        read;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } icb_cmd_t;

    typedef struct {
        logic [SRC_W-1:0] src;
        logic             get;
        logic [31:0]      data;
        logic             err;
    } tl_txn_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        i_icb_cmd_valid = 1'b0;
        i_icb_cmd_addr  = '0;
        i_icb_cmd_read  = 1'b0;
        i_icb_cmd_wdata = '0;
        i_icb_cmd_wmask = '0;
        i_icb_rsp_ready = 1'b1;
        tl_a_ready      = 1'b1;
        tl_d_valid      = 1'b0;
        tl_d_opcode     = '0;
        tl_d_source     = '0;
        tl_d_data       = '0;
        tl_d_error      = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic cmd(input logic rd, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wmask);
        i_icb_cmd_valid = 1'b1;
        i_icb_cmd_read  = rd;
        i_icb_cmd_addr  = addr;
        i_icb_cmd_wdata = wdata;
        i_icb_cmd_wmask = wmask;
    endtask

    task automatic dresp(input logic [SRC_W-1:0] src, input logic [2:0] opc,
                         input logic [31:0] data, input logic err);
        tl_d_valid  = 1'b1;
        tl_d_source = src;
        tl_d_opcode = opc;
        tl_d_data   = data;
        tl_d_error  = err;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t     vecs[6];
    tl_txn_t  slave_q[$];
    rsp_t     exp_q[$];

    initial begin
        vecs[0] = '{1'b1, 32'h2000_0004, 4'h0, 3'd4, 29'h0000_0004, 4'hF};
        vecs[1] = '{1'b0, 32'h1000_0008, 4'h3, 3'd1, 29'h1000_0008, 4'h3};
        vecs[2] = '{1'b0, 32'h1000_0008, 4'hF, 3'd0, 29'h1000_0008, 4'hF};
        vecs[3] = '{1'b0, 32'h0000_0010, 4'h0, 3'd1, 29'h0000_0010, 4'h0};
        vecs[4] = '{1'b0, 32'hFFFF_FFFF, 4'h8, 3'd1, 29'h1FFF_FFFC, 4'h8};
        vecs[5] = '{1'b1, 32'h1234_5679, 4'h5, 3'd4, 29'h1234_5678, 4'hF};

        do_reset();
        at_neg();
        check("reset_busy", busy, 0);
        check("reset_rsp_valid", i_icb_rsp_valid, 0);
        check("reset_d_ready", tl_d_ready, 1);
        check("reset_order_err", order_err, 0);
        check("reset_cmd_ready", i_icb_cmd_ready, 1);

        // A-path encoding table, held with a_ready low so nothing is issued
        tick();
        tl_a_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cmd(vecs[i].read, vecs[i].addr, 32'h5555_0000 + i, vecs[i].wmask);
            at_neg();
            check($sformatf("vec%0d_a_valid", i), tl_a_valid, 1);
            check($sformatf("vec%0d_cmd_ready", i), i_icb_cmd_ready, 0);
            check($sformatf("vec%0d_opcode", i), tl_a_opcode, vecs[i].exp_opcode);
            check($sformatf("vec%0d_address", i), tl_a_address, vecs[i].exp_addr);
            check($sformatf("vec%0d_mask", i), tl_a_mask, vecs[i].exp_mask);
            check($sformatf("vec%0d_size", i), tl_a_size, 2);
            check($sformatf("vec%0d_param", i), tl_a_param, 0);
            check($sformatf("vec%0d_source", i), tl_a_source, 0);
            tick();
        end
        idle_inputs();
        at_neg();
        check("table_no_issue_busy", busy, 0);
        tick();

        // single read round trip
        do_reset();
        cmd(1'b1, 32'h2000_0004, 32'h0, 4'h0);
        at_neg();
        check("s1_opcode", tl_a_opcode, 4);
        check("s1_address", tl_a_address, 29'h4);
        check("s1_source", tl_a_source, 0);
        check("s1_cmd_ready", i_icb_cmd_ready, 1);
        tick();
        idle_inputs();
        at_neg();
        check("s1_busy", busy, 1);
        check("s1_rsp_idle", i_icb_rsp_valid, 0);
        tick();
        dresp(0, 3'd1, 32'hDEAD_BEEF, 1'b0);
        at_neg();
        check("s1_d_ready", tl_d_ready, 1);
        check("s1_rsp_not_same_cycle", i_icb_rsp_valid, 0);
        tick();
        tl_d_valid = 1'b0;
        at_neg();
        check("s1_rsp_valid", i_icb_rsp_valid, 1);
        check("s1_rdata", i_icb_rsp_rdata, 32'hDEAD_BEEF);
        check("s1_err", i_icb_rsp_err, 0);
        tick();
        at_neg();
        check("s1_done_rsp", i_icb_rsp_valid, 0);
        check("s1_done_busy", busy, 0);
        tick();

        // three back-to-back writes against a two-credit limit
        do_reset();
        cmd(1'b0, 32'h100, 32'h1111_1111, 4'hF);
        at_neg();
        check("s2_w0_ready", i_icb_cmd_ready, 1);
        check("s2_w0_src", tl_a_source, 0);
        check("s2_w0_opcode", tl_a_opcode, 0);
        tick();
        cmd(1'b0, 32'h104, 32'h2222_2222, 4'hF);
        at_neg();
        check("s2_w1_ready", i_icb_cmd_ready, 1);
        check("s2_w1_src", tl_a_source, 1);
        tick();
        cmd(1'b0, 32'h108, 32'h3333_3333, 4'hF);
        at_neg();
        check("s2_w2_blocked", i_icb_cmd_ready, 0);
        check("s2_w2_a_valid", tl_a_valid, 0);
        check("s2_busy", busy, 1);
        tick();
        dresp(0, 3'd0, 32'h0, 1'b0);
        at_neg();
        check("s2_blocked_on_d", i_icb_cmd_ready, 0);
        tick();
        tl_d_valid = 1'b0;
        at_neg();
        check("s2_rsp_valid", i_icb_rsp_valid, 1);
        check("s2_write_rdata", i_icb_rsp_rdata, 0);
        check("s2_blocked_until_pop", i_icb_cmd_ready, 0);
        tick();
        at_neg();
        check("s2_w2_ready", i_icb_cmd_ready, 1);
        check("s2_w2_src", tl_a_source, 0);
        tick();
        i_icb_cmd_valid = 1'b0;
        dresp(1, 3'd0, 32'h0, 1'b0);
        at_neg();
        check("s2_d1_ready", tl_d_ready, 1);
        tick();
        dresp(0, 3'd0, 32'h0, 1'b0);
        tick();
        tl_d_valid = 1'b0;
        tick();
        at_neg();
        check("s2_final_busy", busy, 0);
        check("s2_final_rsp", i_icb_rsp_valid, 0);
        check("s2_order_err", order_err, 0);
        tick();

        // response backpressure fills the FIFO
        do_reset();
        i_icb_rsp_ready = 1'b0;
        cmd(1'b0, 32'h200, 32'hAAAA_AAAA, 4'h3);
        tick();
        cmd(1'b1, 32'h204, 32'h0, 4'h0);
        tick();
        i_icb_cmd_valid = 1'b0;
        dresp(0, 3'd0, 32'hCAFE_F00D, 1'b0);
        at_neg();
        check("s4_d0_ready", tl_d_ready, 1);
        tick();
        dresp(1, 3'd1, 32'h1234_5678, 1'b1);
        at_neg();
        check("s4_d1_ready", tl_d_ready, 1);
        tick();
        tl_d_valid = 1'b0;
        at_neg();
        check("s4_full_d_ready", tl_d_ready, 0);
        check("s4_full_rsp_valid", i_icb_rsp_valid, 1);
        check("s4_full_busy", busy, 1);
        tick();
        at_neg();
        check("s4_hold_rsp_valid", i_icb_rsp_valid, 1);
        check("s4_hold_rdata", i_icb_rsp_rdata, 0);
        tick();
        i_icb_rsp_ready = 1'b1;
        at_neg();
        check("s4_r0_rdata", i_icb_rsp_rdata, 0);
        check("s4_r0_err", i_icb_rsp_err, 0);
        tick();
        at_neg();
        check("s4_r1_valid", i_icb_rsp_valid, 1);
        check("s4_r1_rdata", i_icb_rsp_rdata, 32'h1234_5678);
        check("s4_r1_err", i_icb_rsp_err, 1);
        check("s4_d_ready_again", tl_d_ready, 1);
        tick();
        at_neg();
        check("s4_drained_rsp", i_icb_rsp_valid, 0);
        check("s4_drained_busy", busy, 0);
        tick();

        // out-of-order D source
        do_reset();
        cmd(1'b1, 32'h300, 32'h0, 4'h0);
        tick();
        i_icb_cmd_valid = 1'b0;
        dresp(1, 3'd1, 32'hA5A5_A5A5, 1'b0);
        tick();
        tl_d_valid = 1'b0;
        at_neg();
        check("s5_order_err_set", order_err, 1);
        check("s5_still_pushed", i_icb_rsp_valid, 1);
        check("s5_rdata", i_icb_rsp_rdata, 32'hA5A5_A5A5);
        tick();
        tick();
        tick();
        at_neg();
        check("s5_order_err_sticky", order_err, 1);
        check("s5_busy", busy, 0);
        tick();

        // reset with two transactions outstanding (a_ptr currently 1)
        cmd(1'b1, 32'h310, 32'h0, 4'h0);
        tick();
        cmd(1'b1, 32'h314, 32'h0, 4'h0);
        tick();
        i_icb_cmd_valid = 1'b0;
        at_neg();
        check("s6_busy_before", busy, 1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        at_neg();
        check("s6_busy_after", busy, 0);
        check("s6_rsp_after", i_icb_rsp_valid, 0);
        check("s6_order_err_cleared", order_err, 0);
        check("s6_d_ready", tl_d_ready, 1);
        tick();
        cmd(1'b1, 32'h400, 32'h0, 4'h0);
        at_neg();
        check("s6_src_restart", tl_a_source, 0);
        check("s6_cmd_ready", i_icb_cmd_ready, 1);
        tick();
        i_icb_cmd_valid = 1'b0;
        dresp(0, 3'd1, 32'h0BAD_CAFE, 1'b0);
        tick();
        tl_d_valid = 1'b0;
        at_neg();
        check("s6_rdata", i_icb_rsp_rdata, 32'h0BAD_CAFE);
        tick();
        at_neg();
        check("s6_busy_end", busy, 0);
        check("s6_order_err_end", order_err, 0);
        tick();

        // randomized traffic against the transaction model
        do_reset();
        begin
            int       issued = 0;
            int       retired = 0;
            int       dfired = 0;
            bit       have_cmd = 0;
            icb_cmd_t cur;
            cur = '{1'b0, 32'h0, 32'h0, 4'h0};
            for (int cyc = 0; cyc < 4000; cyc++) begin
                bit drain;
                int out_n;
                int fifo_n;
                bit a_fire, d_fire, r_fire;
                drain = (cyc >= 3000);
                if (drain && !have_cmd && issued == retired)
                    break;
                if (!have_cmd && !drain && $urandom_range(0, 99) < 60) begin
                    int k;
                    k = $urandom_range(0, 3);
                    cur.read  = $urandom_range(0, 1);
                    cur.addr  = $urandom;
                    cur.wdata = $urandom;
                    cur.wmask = (k == 0) ? 4'hF : (k == 1) ? 4'h0 : 4'($urandom);
                    have_cmd  = 1;
                end
                i_icb_cmd_valid = have_cmd;
                i_icb_cmd_read  = cur.read;
                i_icb_cmd_addr  = cur.addr;
                i_icb_cmd_wdata = cur.wdata;
                i_icb_cmd_wmask = cur.wmask;
                tl_a_ready      = drain ? 1'b1 : ($urandom_range(0, 99) < 70);
                i_icb_rsp_ready = drain ? 1'b1 : ($urandom_range(0, 99) < 60);
                if (slave_q.size() > 0 && (drain || $urandom_range(0, 99) < 60)) begin
                    dresp(slave_q[0].src, slave_q[0].get ? 3'd1 : 3'd0,
                          slave_q[0].get ? slave_q[0].data : $urandom, slave_q[0].err);
                end else begin
                    tl_d_valid = 1'b0;
                end

                at_neg();
                out_n  = issued - retired;
                fifo_n = dfired - retired;
                check("rnd_busy", busy, out_n != 0);
                check("rnd_a_valid", tl_a_valid, have_cmd && out_n < OUTS);
                check("rnd_cmd_ready", i_icb_cmd_ready, tl_a_ready && out_n < OUTS);
                check("rnd_d_ready", tl_d_ready, fifo_n < OUTS);
                check("rnd_rsp_valid", i_icb_rsp_valid, fifo_n > 0);
                check("rnd_order_err", order_err, 0);

                a_fire = have_cmd && tl_a_ready && out_n < OUTS;
                d_fire = tl_d_valid && fifo_n < OUTS;
                r_fire = i_icb_rsp_ready && fifo_n > 0;

                if (a_fire) begin
                    tl_txn_t t;
                    rsp_t    r;
                    check("rnd_a_opcode", tl_a_opcode,
                          cur.read ? 3'd4 : (cur.wmask == 4'hF) ? 3'd0 : 3'd1);
                    check("rnd_a_source", tl_a_source, issued % OUTS);
                    check("rnd_a_address", tl_a_address, (cur.addr % (1 << TL_AW)) & ~32'h3);
                    check("rnd_a_mask", tl_a_mask, cur.read ? 4'hF : cur.wmask);
                    if (!cur.read)
                        check("rnd_a_data", tl_a_data, cur.wdata);
                    t.src   = SRC_W'(issued % OUTS);
                    t.get   = cur.read;
                    t.data  = $urandom;
                    t.err   = ($urandom_range(0, 9) == 0);
                    r.err   = t.err;
                    r.rdata = cur.read ? t.data : 32'h0;
                    slave_q.push_back(t);
                    exp_q.push_back(r);
                    issued++;
                    have_cmd = 0;
                end
                if (d_fire) begin
                    void'(slave_q.pop_front());
                    dfired++;
                end
                if (r_fire) begin
                    rsp_t e;
                    e = exp_q.pop_front();
                    check("rnd_rsp_rdata", i_icb_rsp_rdata, e.rdata);
                    check("rnd_rsp_err", i_icb_rsp_err, e.err);
                    retired++;
                end
                tick();
            end
            idle_inputs();
            check("rnd_drain_complete", issued - retired, 0);
            check("rnd_drain_pending_cmd", have_cmd, 0);
            at_neg();
            check("rnd_final_busy", busy, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
